if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC and drives the instruction memory

---
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC owner, imem req/ready master, IF/ID slot driver
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   stall                      downstream will not take the slot this cycle
//   redirect_valid/_pc         taken branch/jump from EX; flush and refetch at redirect_pc (word aligned)
//   imem_req/_addr             fetch request and word-aligned address, held until imem_ready
//   imem_ready/_rdata          request completes this cycle, instruction word valid
//   if_pc/if_instr/if_valid    slot presented to IF/ID; if_instr is NOP_INSTR when !if_valid

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] drain_addr;   // address of the orphaned request still being drained
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;

   logic [31:0] target_pc;
   logic [31:0] reset_pc_aligned;
   logic        can_accept;
   logic        consume;
   logic        unused_redirect_bits;

   assign target_pc            = {redirect_pc[31:2], 2'b00};
   assign reset_pc_aligned     = {RESET_PC[31:2], 2'b00};
   assign unused_redirect_bits = ^redirect_pc[1:0];

   assign can_accept = !if_valid || !stall;
   assign consume    = if_valid && !stall;

   // The request is combinational on state so a zero-wait memory can
   // complete in the same cycle; reset gates it off immediately.
   assign imem_req  = !reset && (state != HOLD);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= FETCH;
         pc_q       <= reset_pc_aligned;
         drain_addr <= reset_pc_aligned;
         hold_pc    <= reset_pc_aligned;
         hold_instr <= NOP_INSTR;
         if_pc      <= reset_pc_aligned;
         if_instr   <= NOP_INSTR;
         if_valid   <= 1'b0;
      end else if (redirect_valid) begin
         // Flush wins over stall; any buffered word is simply forgotten.
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
         pc_q     <= target_pc;
         case (state)
            FETCH: begin
               // An outstanding request cannot be abandoned: drain it first.
               if (!imem_ready) begin
                  state      <= DRAIN;
                  drain_addr <= pc_q;
               end
            end
            HOLD:    state <= FETCH;
            DRAIN:   if (imem_ready) state <= FETCH;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  pc_q <= pc_q + 32'd4;
                  if (can_accept) begin
                     if_pc    <= pc_q;
                     if_instr <= imem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     hold_pc    <= pc_q;
                     hold_instr <= imem_rdata;
                     state      <= HOLD;
                  end
               end else if (consume) begin
                  if_valid <= 1'b0;
                  if_instr <= NOP_INSTR;
               end
            end
            HOLD: begin
               // The slot is always full and stalled here, so !stall means
               // it is being consumed and can take the buffered word.
               if (!stall) begin
                  if_pc    <= hold_pc;
                  if_instr <= hold_instr;
                  if_valid <= 1'b1;
                  state    <= FETCH;
               end
            end
            DRAIN: begin
               if (consume) begin
                  if_valid <= 1'b0;
                  if_instr <= NOP_INSTR;
               end
               if (imem_ready) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   int checks = 0;
   int errors = 0;

   // memory model: fixed number of wait states, can be frozen with mem_en=0
   int   waits  = 0;
   int   wcnt   = 0;
   logic mem_en = 1'b1;

   if_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clock(clock), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_rdata = word(imem_addr);
   assign imem_ready = imem_req && mem_en && (wcnt >= waits);

   always @(posedge clock) begin
      if (reset || !imem_req || imem_ready) wcnt <= 0;
      else                                  wcnt <= wcnt + 1;
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: the slot, a queue of fetched-but-unpresented words,
   // the next address to fetch, and whether an orphaned request is in flight.
   logic        m_valid = 1'b0;
   logic [31:0] m_pc    = RPC;
   logic [31:0] m_instr = NOP;
   logic [31:0] fpc     = RPC;
   logic        draining = 1'b0;
   logic [31:0] drain_addr = RPC;
   logic [63:0] q[$];

   task automatic model_step();
      logic [63:0] e;
      if (reset) begin
         m_valid = 1'b0; m_instr = NOP; m_pc = RPC; fpc = RPC;
         q.delete(); draining = 1'b0;
      end else if (redirect_valid) begin
         m_valid = 1'b0; m_instr = NOP;
         if (!draining) drain_addr = fpc;
         draining = (q.size() == 0) && !imem_ready;
         q.delete();
         fpc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (imem_ready) begin
            if (draining) draining = 1'b0;
            else begin
               q.push_back({fpc, word(fpc)});
               fpc = fpc + 32'd4;
            end
         end
         if (!m_valid || !stall) begin
            if (q.size() > 0) begin
               e = q.pop_front();
               m_pc = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
            end else begin
               m_valid = 1'b0; m_instr = NOP;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      logic exp_req;
      @(negedge clock);
      exp_req = !reset && (q.size() == 0);
      cmp("m_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req && imem_req) cmp("m_addr", imem_addr, draining ? drain_addr : fpc);
      cmp("m_valid", {31'd0, if_valid}, {31'd0, m_valid});
      cmp("m_instr", if_instr, m_instr);
      cmp("m_pc", if_pc, m_pc);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      step(3);
      cmp("rst_req", {31'd0, imem_req}, 32'd0);
      cmp("rst_valid", {31'd0, if_valid}, 32'd0);
      cmp("rst_instr", if_instr, NOP);
      cmp("rst_pc", if_pc, RPC);

      // zero-wait streaming
      reset = 1'b0;
      step(1); cmp("t1_pc0", if_pc, 32'h100); cmp("t1_instr0", if_instr, 32'hC0DE_0100);
      cmp("t1_valid0", {31'd0, if_valid}, 32'd1);
      step(1); cmp("t1_pc1", if_pc, 32'h104);
      step(1); cmp("t1_pc2", if_pc, 32'h108); cmp("t1_instr2", if_instr, 32'hC0DE_0108);

      // two wait states
      waits = 2;
      step(1); cmp("t2_bubble0", {31'd0, if_valid}, 32'd0); cmp("t2_addr", imem_addr, 32'h10C);
      step(1); cmp("t2_bubble1", if_instr, NOP); cmp("t2_addr_held", imem_addr, 32'h10C);
      step(1); cmp("t2_pc", if_pc, 32'h10C); cmp("t2_valid", {31'd0, if_valid}, 32'd1);
      step(3); cmp("t2_pc_next", if_pc, 32'h110);

      // stall with data arriving -> hold buffer
      waits = 0; stall = 1'b1;
      step(1); cmp("t3_req", {31'd0, imem_req}, 32'd0); cmp("t3_pc", if_pc, 32'h110);
      step(2); cmp("t3_pc_kept", if_pc, 32'h110);
      stall = 1'b0;
      step(1); cmp("t3_pc_buf", if_pc, 32'h114); cmp("t3_instr_buf", if_instr, 32'hC0DE_0114);
      step(1); cmp("t3_pc_after", if_pc, 32'h118);

      // redirect with request pending -> drain
      mem_en = 1'b0;
      step(1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
      step(1); cmp("t4_drain_req", {31'd0, imem_req}, 32'd1); cmp("t4_drain_addr", imem_addr, 32'h11C);
      redirect_valid = 1'b0;
      step(2); cmp("t4_valid", {31'd0, if_valid}, 32'd0);
      mem_en = 1'b1;
      step(1); cmp("t4_new_addr", imem_addr, 32'h2000); cmp("t4_still_empty", {31'd0, if_valid}, 32'd0);
      step(1); cmp("t4_pc", if_pc, 32'h2000); cmp("t4_instr", if_instr, 32'hC0DE_2000);

      // redirect with ready and stall in the same cycle, then PC wrap
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      step(1); cmp("t5_flush", if_instr, NOP); cmp("t5_pc_kept", if_pc, 32'h2000);
      cmp("t5_addr", imem_addr, 32'hFFFF_FFFC);
      stall = 1'b0; redirect_valid = 1'b0;
      step(1); cmp("t5_pc_top", if_pc, 32'hFFFF_FFFC); cmp("t5_instr_top", if_instr, 32'h3F21_FFFC);
      cmp("t5_wrap_addr", imem_addr, 32'h0);
      step(1); cmp("t5_pc_wrap", if_pc, 32'h0); cmp("t5_instr_wrap", if_instr, 32'hC0DE_0000);

      // reset in the middle of a wait
      waits = 2;
      step(1);
      reset = 1'b1;
      #1 cmp("t6_req_now", {31'd0, imem_req}, 32'd0);
      step(1); cmp("t6_valid", {31'd0, if_valid}, 32'd0); cmp("t6_pc", if_pc, RPC);
      cmp("t6_instr", if_instr, NOP);
      reset = 1'b0; waits = 0;
      step(1); cmp("t6_restart", if_pc, RPC);

      // mixed directed pattern: stalls, varying waits, redirects in all states
      for (int i = 0; i < 80; i++) begin
         stall          = (i % 5 == 3) || (i % 7 == 2);
         waits          = i % 3;
         redirect_valid = (i == 17) || (i == 33) || (i == 34) || (i == 58);
         redirect_pc    = 32'h0000_4000 + 32'(i * 16) + 32'd3;
         step(1);
      end
      stall = 1'b0; redirect_valid = 1'b0; waits = 0;
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
